muladd_vec: RTL
===============

# muladd_vec

Parametrised, pipelined, multi-lane multiply-add unit with a selectable operating mode and a valid/ready handshake. It replaces the single-lane, fixed-width muladd in datapaths that need several unsigned multiply-add or multiply-accumulate lanes per beat. Each accepted beat produces exactly one result beat after a fixed latency, and backpressure stalls the whole pipeline.

## Interface
- WIDTH, 8, operand and result width per lane (unsigned).
- LANES, 4, number of independent lanes.
- STAGES, 2, pipeline depth in cycles (1..4); the last stage is the output register.

- clock  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit accepts a beat this cycle.
- mode  in  2  00 muladd, 01 accumulate, 10 multiply, 11 treated as 00.
- acc_clear  in  1  in mode 01, the beat starts from accumulator 0.
- a, b, c  in  LANES*WIDTH each  lane i at bits [i*WIDTH +: WIDTH].
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts the result.
- y  out  LANES*WIDTH  results, same packing.

## Operation
- Accept when in_valid & in_ready. mode, acc_clear and operands are captured with the beat and travel down the pipeline.
- Per-lane results:
  - 00: y = a*b + c.
  - 01: acc = (acc_clear ? 0 : acc) + a*b; y = new acc. c is ignored.
  - 10: y = a*b.
- Arithmetic is unsigned modulo 2^WIDTH. The product and sum are truncated to the WIDTH LSBs and there is no saturation or overflow flag.
- One accumulator per lane (WIDTH bits), updated only when a mode-01 beat leaves the final stage into the output register. Mode 00 and 10 beats never modify the accumulators; they hold across these beats and across idle cycles.
- Each stage carries its own valid bit. Bubbles propagate and never update the accumulators.
- stall = out_valid & ~out_ready. While stalled, every stage, the accumulators and y hold, and in_ready = 0.
- in_ready = ~stall. This is a combinational function of out_valid and out_ready; in_ready does not depend on in_valid.
- Beats leave in acceptance order. No beat is lost or duplicated.
- Reset clears all stage valid bits, out_valid, y and the accumulators to 0. Reset overrides stall and any in-flight beats, which are discarded.

## Timing
- Latency: a beat accepted at edge k appears with out_valid=1 at edge k+STAGES, given no stall. Each stall cycle adds one cycle.
- Throughput: one beat per cycle while out_ready=1.
- y is registered and changes only at an edge where the output register loads. It is stable while out_valid & ~out_ready.
- out_valid falls the cycle after the transfer if no new beat reaches the output stage.
- Accumulator dependency: back-to-back mode-01 beats on the same lane must each see the previous beat's result. The accumulator add therefore sits in the final stage only; there is no read-ahead of acc in earlier stages.
- Reset value of every output: in_ready=1 after reset (out_valid=0); out_valid=0; y=0. in_ready also reads 1 during reset, but no beat is accepted until the first edge with reset=0.

## Test plan
- Reset: hold reset 16 cycles with in_valid=1 → out_valid=0 and y=0 throughout; first result appears only STAGES cycles after the first post-reset accept.
- Muladd, all lanes (WIDTH=8, LANES=4, STAGES=2): a=4,b=2,c=3 on every lane at edge k → y=11 on all lanes, out_valid=1 at edge k+2 only.
- Wrap: lane0 a=16,b=16,c=5 → 5; lane1 a=255,b=255,c=0 → 1; lane2 a=255,b=1,c=1 → 0; mode 10 lane3 a=200,b=2 → 144.
- Accumulate:
  - Stimulus, back-to-back: mode 01 clear a=4,b=2 → 8; then a=3,b=3 → 17; then mode 00 a=1,b=1,c=9 → 10; then mode 01 a=1,b=1 → 18.
  - Required: no gaps between results; accumulator untouched by the mode-00 beat.
- Backpressure: stream 4 muladd beats (y=1,2,3,4); drop out_ready for 3 cycles while out_valid=1 → y held, in_ready=0, then all 4 results delivered in order, none duplicated.
- Reset mid-operation: assert reset with 2 beats in flight and the accumulators at 17 → out_valid=0 and y=0 next cycle; the following mode-01 beat a=2,b=2 without clear → 4.

Source files
------------

// File: rtl/muladd_vec.sv
// rtl/muladd_vec.sv - pipelined multi-lane unsigned multiply-add / multiply-accumulate unit
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake (in_ready = not stalled)
//   mode, acc_clear     per-beat operation select, travels with the beat
//   a, b, c             LANES packed operands, lane i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready result beat handshake
//   y                   LANES packed results, registered
module muladd_vec #(
   parameter int WIDTH  = 8,
   parameter int LANES  = 4,
   parameter int STAGES = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               mode,
   input  logic                     acc_clear,
   input  logic [LANES*WIDTH-1:0]   a,
   input  logic [LANES*WIDTH-1:0]   b,
   input  logic [LANES*WIDTH-1:0]   c,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [LANES*WIDTH-1:0]   y
);

   localparam int VW = LANES * WIDTH;
   localparam int LS = STAGES - 1;

   logic stall;

   // The whole pipeline freezes only when a finished beat cannot leave.
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // Products are formed at capture; only the accumulator add is deferred
   // to the final stage so back-to-back accumulate beats chain correctly.
   logic [VW-1:0] in_prod;
   logic [1:0]    in_mode;

   always_comb begin
      in_prod = '0;
      for (int i = 0; i < LANES; i++) begin
         in_prod[i*WIDTH +: WIDTH] = a[i*WIDTH +: WIDTH] * b[i*WIDTH +: WIDTH];
      end
   end

   assign in_mode = (mode == 2'b11) ? 2'b00 : mode;

   // Stage 0 is the capture register; stage STAGES-1 feeds the output register.
   logic          st_valid [STAGES];
   logic [1:0]    st_mode  [STAGES];
   logic          st_clr   [STAGES];
   logic [VW-1:0] st_prod  [STAGES];
   logic [VW-1:0] st_c     [STAGES];

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int s = 0; s < STAGES; s++) begin
            st_valid[s] <= 1'b0;
         end
      end else if (!stall) begin
         st_valid[0] <= in_valid;
         st_mode[0]  <= in_mode;
         st_clr[0]   <= acc_clear;
         st_prod[0]  <= in_prod;
         st_c[0]     <= c;
         for (int s = 1; s < STAGES; s++) begin
            st_valid[s] <= st_valid[s-1];
            st_mode[s]  <= st_mode[s-1];
            st_clr[s]   <= st_clr[s-1];
            st_prod[s]  <= st_prod[s-1];
            st_c[s]     <= st_c[s-1];
         end
      end
   end

   logic [VW-1:0] acc;
   logic [VW-1:0] acc_next;
   logic [VW-1:0] y_next;

   always_comb begin
      y_next   = '0;
      acc_next = acc;
      for (int i = 0; i < LANES; i++) begin
         case (st_mode[LS])
            2'b01: begin
               acc_next[i*WIDTH +: WIDTH] =
                  (st_clr[LS] ? {WIDTH{1'b0}} : acc[i*WIDTH +: WIDTH])
                  + st_prod[LS][i*WIDTH +: WIDTH];
               y_next[i*WIDTH +: WIDTH] = acc_next[i*WIDTH +: WIDTH];
            end
            2'b10: begin
               y_next[i*WIDTH +: WIDTH] = st_prod[LS][i*WIDTH +: WIDTH];
            end
            default: begin
               y_next[i*WIDTH +: WIDTH] = st_prod[LS][i*WIDTH +: WIDTH]
                                          + st_c[LS][i*WIDTH +: WIDTH];
            end
         endcase
      end
   end

   // y and the accumulators only move when a real beat enters the output
   // register; bubbles advance out_valid but leave both untouched.
   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0;
         y         <= '0;
         acc       <= '0;
      end else if (!stall) begin
         out_valid <= st_valid[LS];
         if (st_valid[LS]) begin
            y   <= y_next;
            acc <= acc_next;
         end
      end
   end

endmodule
